// File: rtl/seg7_bcd_reader.sv
// seg7_bcd_reader
//   Reads back a multiplexed 7-segment display bus and turns it into BCD.
//
//   The reader registers each {dig_sel, seg_in} pair and waits until the pair
//   has been stable for STABLE_CYCLES samples. It then decodes the pattern into
//   that digit's shadow slot. When every digit has been seen, the shadow frame
//   is published with a one-cycle bcd_valid pulse.
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     seg_in     segments abcdefg (bit 6 = a), 1 = lit
//     dig_sel    one-hot digit enable, bit i = digit i
//     bcd_out    last complete frame, digit i at [4i+3:4i]
//     bcd_valid  one-cycle pulse when bcd_out updates
//     frame_err  OR of digit_err for the frame in bcd_out
//     digit_err  bit i = digit i of that frame was undecodable
module seg7_bcd_reader #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    bcd_valid,
  output logic                    frame_err,
  output logic [NUM_DIGITS-1:0]   digit_err
);

  // The counter runs one step past STABLE_CYCLES and parks there. Capture
  // fires only on the cycle it equals STABLE_CYCLES, which gives exactly one
  // capture per dwell.
  localparam int unsigned CW = $clog2(STABLE_CYCLES + 2);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYCLES + 1);

  logic [NUM_DIGITS-1:0]   sel_q;
  logic [6:0]              seg_q;
  logic [CW-1:0]           cnt;
  logic [NUM_DIGITS-1:0]   seen;
  logic [4*NUM_DIGITS-1:0] shadow_bcd;
  logic [NUM_DIGITS-1:0]   shadow_err;

  logic                    legal;
  logic                    same;
  logic                    capture;
  logic                    publish;
  logic [3:0]              cap_nib;
  logic                    cap_err;
  logic [NUM_DIGITS-1:0]   seen_next;

  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    unique case (s)
      7'b1111110: r = 5'h00;
      7'b0110000: r = 5'h01;
      7'b1101101: r = 5'h02;
      7'b1111001: r = 5'h03;
      7'b0110011: r = 5'h04;
      7'b1011011: r = 5'h05;
      7'b1011111: r = 5'h06;
      7'b1110000: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1110011: r = 5'h09;
      default:    r = 5'h1F;
    endcase
    return r;
  endfunction

  always_comb begin
    legal   = (dig_sel != '0) && ((dig_sel & (dig_sel - NUM_DIGITS'(1))) == '0);
    same    = ({dig_sel, seg_in} == {sel_q, seg_q});
    // A non-zero count implies that sel_q holds a legal one-hot sample.
    capture = (cnt == CNT_CAP);
    publish = &seen;
    {cap_err, cap_nib} = decode(seg_q);
    seen_next = publish ? '0 : seen;
    if (capture) seen_next = seen_next | sel_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q      <= '0;
      seg_q      <= '0;
      cnt        <= '0;
      seen       <= '0;
      shadow_bcd <= '0;
      shadow_err <= '0;
      bcd_out    <= '0;
      bcd_valid  <= 1'b0;
      frame_err  <= 1'b0;
      digit_err  <= '0;
    end else begin
      sel_q <= dig_sel;
      seg_q <= seg_in;

      if (!legal)           cnt <= '0;
      else if (!same)       cnt <= CW'(1);
      else if (cnt != CNT_SAT) cnt <= cnt + CW'(1);

      seen      <= seen_next;
      bcd_valid <= publish;
      if (publish) begin
        bcd_out   <= shadow_bcd;
        digit_err <= shadow_err;
        frame_err <= |shadow_err;
      end

      // A capture on the publish edge lands in the shadow after it has been
      // copied out, so it belongs to the next frame.
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (capture && sel_q[i]) begin
          shadow_bcd[4*i +: 4] <= cap_nib;
          shadow_err[i]        <= cap_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_bcd_reader.sv
module tb_seg7_bcd_reader;
  localparam int unsigned ND = 4;
  localparam int unsigned SC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg_in;
  logic [ND-1:0] dig_sel;
  logic [15:0]   bcd_out;
  logic          bcd_valid;
  logic          frame_err;
  logic [ND-1:0] digit_err;

  seg7_bcd_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .dig_sel   (dig_sel),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .frame_err (frame_err),
    .digit_err (digit_err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned edge_cnt = 0;
  int unsigned n_valid  = 0;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  err;
    int unsigned edge_at;   // 0 = arrival cycle not checked
  } frame_t;
  frame_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1110011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic drive(input logic [ND-1:0] sel, input logic [6:0] seg, input int n);
    dig_sel = sel;
    seg_in  = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] bcd, input logic [3:0] err, input int unsigned at);
    frame_t f;
    f.bcd = bcd; f.err = err; f.edge_at = at;
    sb.push_back(f);
  endtask

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) begin
    if (bcd_valid) begin
      frame_t f;
      n_valid++;
      if (sb.size() == 0) begin
        check_eq("unexpected_valid", 32'(bcd_valid), 32'd0);
      end else begin
        f = sb.pop_front();
        check_eq("bcd_out", 32'(bcd_out), 32'(f.bcd));
        check_eq("digit_err", 32'(digit_err), 32'(f.err));
        check_eq("frame_err", 32'(frame_err), 32'(|f.err));
        if (f.edge_at != 0) check_eq("latency_edge", edge_cnt, f.edge_at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dig_sel = '0; seg_in = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_bcd_out", 32'(bcd_out), 32'h0);
    check_eq("rst_bcd_valid", 32'(bcd_valid), 32'h0);
    check_eq("rst_frame_err", 32'(frame_err), 32'h0);
    check_eq("rst_digit_err", 32'(digit_err), 32'h0);
    rst = 1'b0;
    drive('0, '0, 2);

    // Plain scan 1,2,3,4; also pin the arrival cycle of the valid pulse.
    drive(4'b0001, enc(1), 4);
    drive(4'b0010, enc(2), 4);
    drive(4'b0100, enc(3), 4);
    push(16'h4321, 4'b0000, edge_cnt + SC + 2);
    drive(4'b1000, enc(4), 4);

    // Short dwell of 5 must not be captured; the 6 that follows is.
    push(16'h9996, 4'b0000, 0);
    drive(4'b0001, enc(5), 2);
    drive(4'b0001, enc(6), 3);
    drive(4'b0010, enc(9), 4);
    drive(4'b0100, enc(9), 4);
    drive(4'b1000, enc(9), 4);

    // Undecodable pattern on digit 2.
    push(16'h0F00, 4'b0100, 0);
    drive(4'b0001, enc(0), 4);
    drive(4'b0010, enc(0), 4);
    drive(4'b0100, 7'b0000001, 4);
    drive(4'b1000, enc(0), 4);
    drive('0, '0, 6);

    // Multi-hot and all-zero selects are never captured.
    drive(4'b0011, enc(8), 10);
    drive(4'b0000, enc(8), 10);
    check_eq("illegal_sel_no_valid", n_valid, 32'd3);

    // Reset mid-frame discards the partial frame.
    drive(4'b0001, enc(5), 4);
    drive(4'b0010, enc(6), 4);
    rst = 1'b1; dig_sel = '0;
    @(negedge clk);
    check_eq("midrst_bcd_out", 32'(bcd_out), 32'h0);
    check_eq("midrst_digit_err", 32'(digit_err), 32'h0);
    check_eq("midrst_frame_err", 32'(frame_err), 32'h0);
    rst = 1'b0;
    drive(4'b0100, enc(7), 4);
    drive(4'b1000, enc(8), 4);
    drive('0, '0, 6);
    check_eq("partial_no_valid", n_valid, 32'd3);
    push(16'h8721, 4'b0000, 0);
    drive(4'b0001, enc(1), 4);
    drive(4'b0010, enc(2), 4);
    drive('0, '0, 8);

    check_eq("sb_drained", sb.size(), 32'd0);
    check_eq("total_valid", n_valid, 32'd4);
    check_eq("hold_bcd_out", 32'(bcd_out), 32'h8721);
    check_eq("hold_valid_low", 32'(bcd_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
